detection_axi_writer: RTL and testbench
=======================================

# detection_axi_writer

Drains the detection/log path's command FIFO (64-bit) and write-data FIFO (128-bit) and turns each command into one AXI4 INCR write burst to DDR. Sits directly downstream of the detection-log buffer, between its two FIFOs and the PS DDR HP port. It runs one burst at a time and reports completion, errors and activity for the interrupt/debug logic.

## Interface
Parameters:
- `BRESP_TIMEOUT`, 65535: cycles to wait for BVALID before abandoning a burst.
- `AXI_ID`, 0: constant AWID.
- `AXI_CACHE`, 4'b0011: constant AWCACHE.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_dout`  in  64  command FIFO head (FWFT), `[11:0]`=byte count−1, `[43:12]`=start address, `[63]` reserved.
- `cmd_empty`  in  1  command FIFO empty.
- `cmd_rd_en`  out  1  command pop.
- `dat_dout`  in  128  data FIFO head (FWFT).
- `dat_empty`  in  1  data FIFO empty.
- `dat_rd_en`  out  1  data pop.
- `m_axi_aw*`  out  awaddr 32, awlen 8, awsize 3 (=3'b100), awburst 2 (=INCR), awcache 4, awid 1, awvalid 1.
- `m_axi_awready`  in  1.
- `m_axi_wdata` 128, `m_axi_wstrb` 16 (all ones), `m_axi_wlast` 1, `m_axi_wvalid` 1  out.
- `m_axi_wready`  in  1.
- `m_axi_bresp` 2, `m_axi_bvalid` 1  in.
- `m_axi_bready`  out  1.
- `err_clr`  in  1  clears `err_flags`.
- `busy`  out  1  state ≠ IDLE.
- `burst_done`  out  1  one-cycle pulse per completed burst.
- `burst_cnt`  out  32  completed bursts, wraps.
- `err_flags`  out  4  sticky `{timeout, bnd4k, len_fmt, bresp}`.

## Operation
- FSM: IDLE → AW → W → B → IDLE.
- IDLE, `~cmd_empty`: `cmd_rd_en`=1 for one cycle. Latch address and `beats = cmd[11:4]+1` (1..256). Go to AW.
- Format check on latch:
  - `cmd[3:0]≠4'hF` sets `len_fmt`.
  - `addr[11:0] + bytes > 4096` sets `bnd4k`.
  - The burst is still issued in both cases.
- AW: `awvalid`=1, `awlen=beats−1`. Leave on `awvalid & awready`.
- W:
  - `wvalid = ~dat_empty`, `wdata = dat_dout`, `dat_rd_en = wvalid & wready`.
  - Beat counter increments on each handshake. `wlast` is asserted when the counter equals `beats−1`.
  - After the last handshake, go to B.
- B:
  - `bready`=1. On `bvalid`, if `bresp≠OKAY` set `bresp`.
  - Pulse `burst_done`, increment `burst_cnt`, return to IDLE.
  - If the wait counter reaches `BRESP_TIMEOUT`: set `timeout`, return to IDLE, no `burst_done`.
- `err_clr` clears all four flags. If an error event occurs in the same cycle, the set wins.

## Timing
- Reset values: all valid/ready/rd_en/`wlast`/`busy`/`burst_done` 0, `burst_cnt` 0, `err_flags` 0, `awaddr`/`awlen` 0.
- Command pop to `awvalid`: 1 cycle.
- AW handshake to first possible `wvalid`: 1 cycle.
- Steady state: 1 beat/cycle with the data FIFO non-empty and `wready` high.
- `dat_empty` mid-burst: `wvalid` drops and `wlast` is held. Resume without loss.
- AW and W channels:
  - `awvalid` holds until accepted.
  - W never precedes the AW handshake.
  - `bready` is only high in B.
- Minimum burst-to-burst gap: 1 IDLE cycle.
- `rst` mid-burst: immediate return to IDLE and valids drop. The interconnect shares this reset.
- `burst_cnt` wraps 0xFFFFFFFF→0.

## Structure
- Shared package `detection_axi_pkg`:
  - FSM state enum.
  - Command field positions (`CMD_LEN_MSB/LSB`, `CMD_ADDR_MSB/LSB`).
  - `AXI_SIZE_16B`, `AXI_BURST_INCR`, `RESP_OKAY`.
  - Error bit indices.
- Single flat module. The B-channel watchdog counter may be a sub-module `detection_axi_watchdog` (load/enable/expire).

## Test plan
- Command `{addr=0x6030_0000, cnt=4095}`, 256 data words, `awready`/`wready` always high → `awlen`=255, 256 beats, `wlast` on beat 255, `burst_done`, `burst_cnt`=1, no errors.
- Same command with `wready` toggling 50% and `dat_empty` bubbles → all 256 words in order, no duplicates or drops, `wlast` only on the final handshake.
- Command `cnt=0x0F7` (248 bytes, `[3:0]`=7) → `awlen`=15, `err_flags`=4'b0010.
- Address `0x6000_0800` with `cnt=4095` → `bnd4k` set, burst still completes.
- `bvalid` with `bresp`=SLVERR → `err_flags[0]`=1, `burst_done` pulses. Then `err_clr` → flags 0.
- `bvalid` withheld for `BRESP_TIMEOUT` cycles → `timeout` set, no `burst_done`. Next command proceeds normally. Assert `rst` mid-W → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/detection_axi_pkg.sv
// Shared types and constants for the detection-log AXI4 burst writer.
// Command word layout, AXI encodings and error flag bit positions live here.
package detection_axi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  localparam int CMD_LEN_MSB  = 11;
  localparam int CMD_LEN_LSB  = 0;
  localparam int CMD_BEAT_LSB = 4;
  localparam int CMD_ADDR_MSB = 43;
  localparam int CMD_ADDR_LSB = 12;

  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  localparam int ERR_BRESP   = 0;
  localparam int ERR_LEN_FMT = 1;
  localparam int ERR_BND4K   = 2;
  localparam int ERR_TIMEOUT = 3;

endpackage

// File: rtl/detection_axi_watchdog.sv
// B-channel watchdog: cleared on load, counts while enabled, and flags expiry
// on the TIMEOUT-th enabled cycle.
module detection_axi_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + 32'd1;
    end
  end

  assign expire = en && (count == 32'(TIMEOUT - 1));

endmodule

// File: rtl/detection_axi_writer.sv
// Drains the detection-log command/data FIFOs and issues one AXI4 INCR write
// burst per command, one burst in flight at a time.
module detection_axi_writer
  import detection_axi_pkg::*;
#(
  parameter int         BRESP_TIMEOUT = 65535,
  parameter logic [0:0] AXI_ID        = 1'b0,
  parameter logic [3:0] AXI_CACHE     = 4'b0011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  cmd_dout,
  input  logic         cmd_empty,
  output logic         cmd_rd_en,
  input  logic [127:0] dat_dout,
  input  logic         dat_empty,
  output logic         dat_rd_en,
  output logic [31:0]  m_axi_awaddr,
  output logic [7:0]   m_axi_awlen,
  output logic [2:0]   m_axi_awsize,
  output logic [1:0]   m_axi_awburst,
  output logic [3:0]   m_axi_awcache,
  output logic [0:0]   m_axi_awid,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [127:0] m_axi_wdata,
  output logic [15:0]  m_axi_wstrb,
  output logic         m_axi_wlast,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  input  logic         err_clr,
  output logic         busy,
  output logic         burst_done,
  output logic [31:0]  burst_cnt,
  output logic [3:0]   err_flags
);

  state_t     state;
  logic [7:0] beat_cnt;
  logic       w_hs;
  logic       wd_load;
  logic       wd_expire;
  logic [12:0] burst_end;
  logic [3:0] err_set;
  logic       unused_cmd;

  assign unused_cmd = ^cmd_dout[63:CMD_ADDR_MSB+1];

  assign cmd_rd_en     = (state == S_IDLE) && !cmd_empty && !rst;
  assign m_axi_awsize  = AXI_SIZE_16B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awcache = AXI_CACHE;
  assign m_axi_awid    = AXI_ID;
  assign m_axi_wdata   = dat_dout;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state == S_W) && !dat_empty;
  assign m_axi_wlast   = (state == S_W) && (beat_cnt == m_axi_awlen);
  assign w_hs          = m_axi_wvalid && m_axi_wready;
  assign dat_rd_en     = w_hs;
  assign m_axi_bready  = (state == S_B);
  assign busy          = (state != S_IDLE);
  assign wd_load       = w_hs && m_axi_wlast;

  // Offset of the first byte past the burst within its 4 KB page; 13 bits
  // hold the worst case of 4095 + 4096.
  assign burst_end = {1'b0, cmd_dout[CMD_ADDR_LSB+11:CMD_ADDR_LSB]}
                   + {1'b0, cmd_dout[CMD_LEN_MSB:CMD_LEN_LSB]} + 13'd1;

  detection_axi_watchdog #(
    .TIMEOUT (BRESP_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wd_load),
    .en     (state == S_B),
    .expire (wd_expire)
  );

  always_comb begin
    err_set = '0;
    if (cmd_rd_en) begin
      err_set[ERR_LEN_FMT] = (cmd_dout[CMD_BEAT_LSB-1:CMD_LEN_LSB] != 4'hF);
      err_set[ERR_BND4K]   = (burst_end > 13'd4096);
    end
    if (state == S_B) begin
      err_set[ERR_BRESP]   = m_axi_bvalid && (m_axi_bresp != RESP_OKAY);
      err_set[ERR_TIMEOUT] = !m_axi_bvalid && wd_expire;
    end
  end

  // A new error event takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flags <= '0;
    end else begin
      err_flags <= (err_clr ? 4'b0000 : err_flags) | err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      beat_cnt      <= '0;
      burst_done    <= 1'b0;
      burst_cnt     <= '0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!cmd_empty) begin
            m_axi_awaddr  <= cmd_dout[CMD_ADDR_MSB:CMD_ADDR_LSB];
            m_axi_awlen   <= cmd_dout[CMD_LEN_MSB:CMD_BEAT_LSB];
            m_axi_awvalid <= 1'b1;
            beat_cnt      <= '0;
            state         <= S_AW;
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            state         <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            if (m_axi_wlast) begin
              state <= S_B;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            burst_done <= 1'b1;
            burst_cnt  <= burst_cnt + 32'd1;
            state      <= S_IDLE;
          end else if (wd_expire) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detection_axi_writer.sv
// Directed bench for detection_axi_writer with FIFO models, an AXI slave
// responder and a scoreboard of expected AW requests and W data.
module tb_detection_axi_writer;

  localparam int TO = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  cmd_dout;
  logic         cmd_empty;
  logic         cmd_rd_en;
  logic [127:0] dat_dout;
  logic         dat_empty;
  logic         dat_rd_en;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [3:0]   awcache;
  logic [0:0]   awid;
  logic         awvalid;
  logic         awready = 1'b1;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready = 1'b1;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;
  logic         bready;
  logic         err_clr = 1'b0;
  logic         busy;
  logic         burst_done;
  logic [31:0]  burst_cnt;
  logic [3:0]   err_flags;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0]  cmd_mem [0:15];
  logic [127:0] dat_mem [0:1023];
  int cmd_wp = 0, cmd_rp = 0, dat_wp = 0, dat_rp = 0;
  logic bubble = 1'b0;
  bit   rand_mode = 1'b0;
  bit   b_withhold = 1'b0;
  logic [1:0] b_resp_cfg = 2'b00;

  logic [127:0] data_exp [$];
  logic [39:0]  aw_exp [$];

  int done_count = 0, beat_total = 0, wlast_total = 0;
  int busy_cycles = 0, bready_cycles = 0;
  bit aw_active = 1'b0, prev_cmd_rd = 1'b0, prev_aw_wait = 1'b0;
  int beat_idx = 0;
  logic [7:0] cur_len = '0;

  assign cmd_empty = (cmd_rp == cmd_wp);
  assign cmd_dout  = cmd_mem[cmd_rp[3:0]];
  assign dat_empty = (dat_rp == dat_wp) || bubble;
  assign dat_dout  = dat_mem[dat_rp[9:0]];

  detection_axi_writer #(
    .BRESP_TIMEOUT (TO),
    .AXI_ID        (1'b0),
    .AXI_CACHE     (4'b0011)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_dout      (cmd_dout),
    .cmd_empty     (cmd_empty),
    .cmd_rd_en     (cmd_rd_en),
    .dat_dout      (dat_dout),
    .dat_empty     (dat_empty),
    .dat_rd_en     (dat_rd_en),
    .m_axi_awaddr  (awaddr),
    .m_axi_awlen   (awlen),
    .m_axi_awsize  (awsize),
    .m_axi_awburst (awburst),
    .m_axi_awcache (awcache),
    .m_axi_awid    (awid),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wlast   (wlast),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .err_clr       (err_clr),
    .busy          (busy),
    .burst_done    (burst_done),
    .burst_cnt     (burst_cnt),
    .err_flags     (err_flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Loads data words into the data FIFO model, then the command; the
  // scoreboard gets the expected AW request and every expected W word.
  task automatic applyStimulus(input logic [31:0] addr, input logic [11:0] cnt, input int nwords);
    logic [127:0] w;
    for (int i = 0; i < nwords; i++) begin
      w = {$urandom, $urandom, 16'(i), 16'hA5A5, $urandom};
      dat_mem[dat_wp[9:0]] = w;
      data_exp.push_back(w);
      dat_wp++;
    end
    aw_exp.push_back({addr, cnt[11:4]});
    cmd_mem[cmd_wp[3:0]] = {20'h0, addr, cnt};
    cmd_wp++;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic waitDone(input int target, input int limit);
    for (int i = 0; i < limit && done_count < target; i++) step();
    checkOutput("burst_done_seen", 128'(done_count), 128'(target));
  endtask

  // FIFO models pop on the edge where the DUT asserted rd_en.
  always @(posedge clk) begin
    if (rst) begin
      cmd_rp <= cmd_wp;
      dat_rp <= dat_wp;
    end else begin
      if (cmd_rd_en) cmd_rp <= cmd_rp + 1;
      if (dat_rd_en) dat_rp <= dat_rp + 1;
    end
  end

  // Slave side: ready/bubble patterns and the write response.
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      wready  = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      bubble  = ($urandom_range(0, 3) == 0);
    end else begin
      wready  = 1'b1;
      awready = 1'b1;
      bubble  = 1'b0;
    end
    bvalid = bready && !b_withhold;
    bresp  = b_resp_cfg;
  end

  // Protocol monitor and scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    logic [39:0] a;
    logic [127:0] d;
    if (rst) begin
      aw_active    = 1'b0;
      prev_cmd_rd  = 1'b0;
      prev_aw_wait = 1'b0;
    end else begin
      if (prev_cmd_rd) checkOutput("pop_to_awvalid", 128'(awvalid), 128'(1));
      if (prev_aw_wait) checkOutput("awvalid_hold", 128'(awvalid), 128'(1));
      prev_cmd_rd  = cmd_rd_en;
      prev_aw_wait = awvalid && !awready;
      if (wvalid) begin
        checkOutput("w_after_aw", 128'(aw_active), 128'(1));
        if (wready) begin
          checkOutput("sb_nonempty", 128'(data_exp.size() > 0), 128'(1));
          if (data_exp.size() > 0) begin
            d = data_exp.pop_front();
            checkOutput("wdata", wdata, d);
          end
          checkOutput("wlast", 128'(wlast), 128'(beat_idx == int'(cur_len)));
          beat_idx++;
          beat_total++;
          if (wlast) begin
            wlast_total++;
            aw_active = 1'b0;
          end
        end
      end
      if (awvalid && awready) begin
        checkOutput("aw_sb_nonempty", 128'(aw_exp.size() > 0), 128'(1));
        if (aw_exp.size() > 0) begin
          a = aw_exp.pop_front();
          checkOutput("awaddr", 128'(awaddr), 128'(a[39:8]));
          checkOutput("awlen", 128'(awlen), 128'(a[7:0]));
          cur_len = a[7:0];
        end
        checkOutput("aw_const", 128'({awsize, awburst, awcache, awid, wstrb}),
                    128'({3'b100, 2'b01, 4'b0011, 1'b0, 16'hFFFF}));
        beat_idx  = 0;
        aw_active = 1'b1;
      end
      if (burst_done) done_count++;
      if (busy) busy_cycles++;
      if (bready) bready_cycles++;
    end
  end

  initial begin
    int snap_busy, snap_beats, snap_wlast, snap_bready, snap_done;
    repeat (3) step();
    rst = 1'b0;
    checkOutput("rst_valids", 128'({awvalid, wvalid, wlast, bready, cmd_rd_en, dat_rd_en}), 128'(0));
    checkOutput("rst_status", 128'({busy, burst_done, burst_cnt, err_flags}), 128'(0));
    checkOutput("rst_aw", 128'({awaddr, awlen}), 128'(0));

    $display("[TB] full 256-beat burst, always ready");
    snap_busy = busy_cycles; snap_beats = beat_total; snap_wlast = wlast_total;
    applyStimulus(32'h6030_0000, 12'd4095, 256);
    waitDone(1, 600);
    checkOutput("t1_burst_cnt", 128'(burst_cnt), 128'(1));
    checkOutput("t1_err", 128'(err_flags), 128'(0));
    checkOutput("t1_beats", 128'(beat_total - snap_beats), 128'(256));
    checkOutput("t1_wlast_cnt", 128'(wlast_total - snap_wlast), 128'(1));
    checkOutput("t1_busy_cycles", 128'(busy_cycles - snap_busy), 128'(258));
    checkOutput("t1_sb_empty", 128'(data_exp.size()), 128'(0));

    $display("[TB] 256-beat burst with random ready and FIFO bubbles");
    snap_beats = beat_total;
    rand_mode = 1'b1;
    applyStimulus(32'h6030_0000, 12'd4095, 256);
    waitDone(2, 3000);
    rand_mode = 1'b0;
    step();
    checkOutput("t2_burst_cnt", 128'(burst_cnt), 128'(2));
    checkOutput("t2_beats", 128'(beat_total - snap_beats), 128'(256));
    checkOutput("t2_sb_empty", 128'(data_exp.size()), 128'(0));

    $display("[TB] malformed length");
    applyStimulus(32'h6030_1000, 12'h0F7, 16);
    waitDone(3, 200);
    checkOutput("t3_err", 128'(err_flags), 128'(4'b0010));

    $display("[TB] 4KB crossing with clear held during the pop");
    err_clr = 1'b1;
    applyStimulus(32'h6000_0800, 12'd4095, 256);
    for (int i = 0; i < 20 && !awvalid; i++) step();
    checkOutput("t4_set_wins", 128'(err_flags), 128'(4'b0100));
    err_clr = 1'b0;
    waitDone(4, 600);
    checkOutput("t4_err", 128'(err_flags), 128'(4'b0100));
    checkOutput("t4_burst_cnt", 128'(burst_cnt), 128'(4));
    err_clr = 1'b1; step(); err_clr = 1'b0;

    $display("[TB] SLVERR response");
    b_resp_cfg = 2'b10;
    applyStimulus(32'h6031_0000, 12'h01F, 2);
    waitDone(5, 100);
    b_resp_cfg = 2'b00;
    checkOutput("t5_err", 128'(err_flags), 128'(4'b0001));
    checkOutput("t5_burst_cnt", 128'(burst_cnt), 128'(5));
    err_clr = 1'b1; step(); err_clr = 1'b0; step();
    checkOutput("t5_err_clr", 128'(err_flags), 128'(0));

    $display("[TB] write response timeout");
    b_withhold = 1'b1;
    snap_bready = bready_cycles; snap_done = done_count;
    applyStimulus(32'h6032_0000, 12'h00F, 1);
    for (int i = 0; i < 20 && !busy; i++) step();
    for (int i = 0; i < TO + 50 && busy; i++) step();
    checkOutput("t6_idle", 128'(busy), 128'(0));
    checkOutput("t6_err", 128'(err_flags), 128'(4'b1000));
    checkOutput("t6_no_done", 128'(done_count), 128'(snap_done));
    checkOutput("t6_burst_cnt", 128'(burst_cnt), 128'(5));
    checkOutput("t6_wait_len", 128'(bready_cycles - snap_bready), 128'(TO));
    b_withhold = 1'b0;
    applyStimulus(32'h6033_0000, 12'h03F, 4);
    waitDone(6, 100);
    checkOutput("t7_burst_cnt", 128'(burst_cnt), 128'(6));

    $display("[TB] reset in the middle of the data phase");
    snap_beats = beat_total;
    applyStimulus(32'h6034_0000, 12'd4095, 256);
    for (int i = 0; i < 100 && (beat_total - snap_beats) < 20; i++) step();
    rst = 1'b1;
    data_exp.delete();
    aw_exp.delete();
    step();
    checkOutput("t8_valids", 128'({awvalid, wvalid, wlast, bready, cmd_rd_en, dat_rd_en}), 128'(0));
    checkOutput("t8_status", 128'({busy, burst_done, burst_cnt, err_flags}), 128'(0));
    checkOutput("t8_aw", 128'({awaddr, awlen}), 128'(0));
    rst = 1'b0;
    repeat (3) step();
    checkOutput("t8_idle", 128'(busy), 128'(0));

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
